// File: rtl/noc_pkg.sv
// Shared Hermes NoC definitions: port names, default flit width and the
// mapping from a directed port pair onto a link-buffer lane number.
package noc_pkg;

    typedef enum logic [2:0] {
        EAST  = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        SOUTH = 3'd3,
        LOCAL = 3'd4
    } e_port;

    localparam int DEFAULT_FLIT_WIDTH = 32;
    localparam int LANE_NONE          = 4;

    // Lane 0/1 cover the two directions of an east-west link, 2/3 north-south.
    function automatic int lane_index(input e_port src, input e_port dst);
        int lane;
        lane = LANE_NONE;
        if (src == EAST && dst == WEST)       lane = 0;
        else if (src == WEST && dst == EAST)  lane = 1;
        else if (src == NORTH && dst == SOUTH) lane = 2;
        else if (src == SOUTH && dst == NORTH) lane = 3;
        return lane;
    endfunction

endpackage

// File: rtl/noc_link_lane_fifo.sv
// One lane of the NoC link buffer: credit-compatible FIFO without bypass.
// Optional statistics counters are built when NOC_LINK_STATS_EN is defined.
module noc_link_lane_fifo
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = DEFAULT_FLIT_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx,
    input  logic [FLIT_WIDTH-1:0]   data_i,
    output logic                    credit_o,
    output logic                    tx,
    output logic [FLIT_WIDTH-1:0]   data_o,
    input  logic                    credit_i
`ifdef NOC_LINK_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [31:0]             flit_count,
    output logic [$clog2(DEPTH):0]  high_water
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  push;
    logic                  pop;

    // Handshake outputs come only from the registered count, gated by reset.
    assign credit_o = (count != FULL) && !reset;
    assign tx       = (count != '0) && !reset;
    assign data_o   = tx ? mem[rd_ptr] : '0;
    assign push     = rx && credit_o;
    assign pop      = tx && credit_i;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Storage needs no reset: data_o is masked whenever the lane is empty.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= data_i;
    end

`ifdef NOC_LINK_STATS_EN
    always_ff @(posedge clock) begin
        if (reset || stats_clr) begin
            flit_count <= '0;
            high_water <= '0;
        end else begin
            if (pop && (flit_count != '1))
                flit_count <= flit_count + 1'b1;
            if (count_next > high_water)
                high_water <= count_next;
        end
    end
`endif

endmodule

// File: rtl/noc_link_buffer.sv
// Multi-lane elastic link stage for the Hermes mesh; one independent FIFO per
// lane. Statistics ports exist only when NOC_LINK_STATS_EN is defined.
module noc_link_buffer
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = DEFAULT_FLIT_WIDTH,
    parameter int DEPTH      = 4,
    parameter int NUM_LANES  = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_LANES-1:0]               rx,
    input  logic [NUM_LANES*FLIT_WIDTH-1:0]    data_i,
    output logic [NUM_LANES-1:0]               credit_o,
    output logic [NUM_LANES-1:0]               tx,
    output logic [NUM_LANES*FLIT_WIDTH-1:0]    data_o,
    input  logic [NUM_LANES-1:0]               credit_i
`ifdef NOC_LINK_STATS_EN
    ,
    input  logic                               stats_clr,
    output logic [NUM_LANES*32-1:0]            flit_count,
    output logic [NUM_LANES*($clog2(DEPTH)+1)-1:0] high_water
`endif
);

    localparam int HW = $clog2(DEPTH) + 1;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        noc_link_lane_fifo #(
            .FLIT_WIDTH (FLIT_WIDTH),
            .DEPTH      (DEPTH)
        ) u_lane (
            .clock      (clock),
            .reset      (reset),
            .rx         (rx[k]),
            .data_i     (data_i[k*FLIT_WIDTH +: FLIT_WIDTH]),
            .credit_o   (credit_o[k]),
            .tx         (tx[k]),
            .data_o     (data_o[k*FLIT_WIDTH +: FLIT_WIDTH]),
            .credit_i   (credit_i[k])
`ifdef NOC_LINK_STATS_EN
            ,
            .stats_clr  (stats_clr),
            .flit_count (flit_count[k*32 +: 32]),
            .high_water (high_water[k*HW +: HW])
`endif
        );
    end

endmodule

// File: doc/noc_link_buffer.md
# noc_link_buffer

Parametrised, multi-lane elastic link stage for the Hermes mesh. It is inserted on a router-to-router link (or a border port) in the manycore top in place of a direct wire connection, so long or congested links are pipelined without breaking credit-based flow control. Each lane is an independent FIFO with a credit-compatible upstream interface and a valid/credit downstream interface. Lane count, depth and flit width are all set by parameters.

## Interface
Parameters:
- FLIT_WIDTH, 32, flit width in bits
- DEPTH, 4, flits buffered per lane; power of two, ≥ 2
- NUM_LANES, 2, independent lanes (2 = one bidirectional link: EAST→WEST and WEST→EAST)

Ports:
- clock  in  1  single clock for all lanes
- reset  in  1  synchronous, active-high
- rx  in  NUM_LANES  upstream flit valid, per lane
- data_i  in  NUM_LANES×FLIT_WIDTH  upstream flit, per lane (packed, lane 0 in LSBs)
- credit_o  out  NUM_LANES  lane can accept a flit this cycle
- tx  out  NUM_LANES  downstream flit valid
- data_o  out  NUM_LANES×FLIT_WIDTH  downstream flit
- credit_i  in  NUM_LANES  downstream router accepts the flit
- stats_clr  in  1  clears statistics (present only with NOC_LINK_STATS_EN)
- flit_count  out  NUM_LANES×32  flits forwarded per lane (present only with NOC_LINK_STATS_EN)
- high_water  out  NUM_LANES×($clog2(DEPTH)+1)  peak occupancy per lane (present only with NOC_LINK_STATS_EN)

## Operation
- Lanes are fully independent. No arbitration or shared state exists between lanes.
- Push: rx[k] && credit_o[k] writes data_i[k] at the tail. When credit_o[k] is low, rx is ignored and the flit is not written. Upstream Hermes ports never assert rx without credit.
- credit_o[k] = (count[k] != DEPTH) && !reset.
- Pop: tx[k] && credit_i[k] advances the head.
- tx[k] = (count[k] != 0).
- data_o[k] = head entry when tx[k] is high, and all-zero when the lane is empty.
- Count update per cycle:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- Push and pop in the same cycle are legal at every occupancy from 1 to DEPTH−1.
- Full: credit_o stays low, and a pop in that cycle frees one slot from the next cycle onward.
- Empty: there is no bypass. A flit pushed into an empty lane appears on data_o one cycle later.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- Flit order is preserved per lane. The buffer does not interpret packet header or size flits.
- Reset mid-operation: all buffered flits are discarded with no flush handshake. Upstream credit is withheld while reset is high.

## Timing
- Reset values:
  - tx = 0, data_o = 0, credit_o = 0 while reset is high
  - credit_o = 1 on the first cycle after reset deasserts
  - pointers and counts = 0
  - flit_count = 0, high_water = 0
- Latency from rx to tx is 1 cycle. Sustained throughput is 1 flit per cycle per lane when credit_i is held high.
- credit_o and tx are derived only from registered count. There is no combinational path from credit_i to credit_o, or from rx to tx.
- DEPTH = 2 sustains full throughput because push and pop can occur in the same cycle.

## Configuration
- NOC_LINK_STATS_EN defined:
  - stats_clr, flit_count and high_water ports exist.
  - flit_count[k] increments on every pop and saturates at 2^32−1.
  - high_water[k] = max(high_water[k], next count[k]), updated each cycle.
  - stats_clr has priority over increment in the same cycle. The result after a clear is 0, not 1.
  - Statistics are also cleared by reset.
- NOC_LINK_STATS_EN undefined: statistic ports and registers are absent, and the datapath is unchanged.

## Structure
- Shared package noc_pkg:
  - e_port enum (EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4)
  - default FLIT_WIDTH
  - lane-index helper function mapping a port pair to a lane number
- Sub-module noc_link_lane_fifo holds one lane's FIFO, count and optional statistics. It is instantiated NUM_LANES times by a generate loop.
- The top level only slices the packed buses.

## Test plan
- Single flit: reset for 2 cycles, rx[0]=1 with data_i 0xCAFE0001 for 1 cycle and credit_i[0]=1 → tx[0]=1 with data_o 0xCAFE0001 exactly one cycle later, for one cycle; lane 1 stays tx=0.
- Fill and backpressure: DEPTH=4, credit_i=0, push 0x10..0x13 → credit_o falls after the 4th push. A 5th rx is ignored. Raising credit_i drains 0x10..0x13 in order on consecutive cycles.
- Streaming: DEPTH=2, rx and credit_i held high, push 0..99 → 100 flits out in order on 100 consecutive cycles, with credit_o never low.
- Simultaneous push and pop at count=3 → count stays 3 and order is preserved. Wrap-around check: after 10 fill/drain cycles of DEPTH flits each, the data remains correct.
- Reset mid-operation: 3 flits buffered, reset for 1 cycle → tx=0 and data_o=0 during reset, credit_o=1 the cycle after reset deasserts, and the old flits never appear.
- Statistics (NOC_LINK_STATS_EN defined): forward 7 flits on lane 1 with a peak occupancy of 3 → flit_count[1]=7 and high_water[1]=3. Then stats_clr during a pop → flit_count[1]=0 on the next cycle.
